flick_conditioner: RTL and testbench

- Upstream conditioning stage for the bound flasher's `flick` input.
- Synchronises a raw, asynchronous, bouncy button/switch level into the `clk` domain and debounces it with a 4-state FSM.
- Outputs a clean `flick_out` level, which drives the flasher's `flick` port, plus single-cycle rise/fall strobes for other consumers.

---
 rtl/flick_conditioner.sv | 98 +++++++++
 tb/tb_flick_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/flick_conditioner.sv
// flick_conditioner: two-flop synchroniser plus 4-state debounce FSM for the flasher's flick input.
// Define FLICK_GLITCH_CNT_EN to add a saturating count of rejected glitches on glitch_cnt.
module flick_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flick_raw,
  output logic flick_out,
  output logic flick_rise,
  output logic flick_fall
`ifdef FLICK_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);
  typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic out_q, out_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        state_d = s2_q ? RISE_CHK : LOW;
        cnt_d   = s2_q ? CNT_W'(1) : '0;
      end
      RISE_CHK:
        if (!s2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      HIGH: begin
        state_d = s2_q ? HIGH : FALL_CHK;
        cnt_d   = s2_q ? '0 : CNT_W'(1);
      end
      FALL_CHK:
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
    out_d = (state_d == HIGH) || (state_d == FALL_CHK);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= flick_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign flick_out  = out_q;
  assign flick_rise = rise_q;
  assign flick_fall = fall_q;
`ifdef FLICK_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;
  logic abort;
  always_comb begin
    abort    = (state_q == RISE_CHK && !s2_q) || (state_q == FALL_CHK && s2_q);
    glitch_d = (abort && glitch_q != 8'hFF) ? glitch_q + 8'd1 : glitch_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) glitch_q <= 8'd0;
    else glitch_q <= glitch_d;
  end
  assign glitch_cnt = glitch_q;
`endif
endmodule

// File: tb/tb_flick_conditioner.sv
// tb_flick_conditioner: scoreboard bench; expected strobe type and edge pushed at stimulus, popped when a strobe appears.
module tb_flick_conditioner;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b0, flick_raw = 1'b0;
  logic flick_out, flick_rise, flick_fall;
`ifdef FLICK_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif
  int cyc = 0, pass_cnt = 0, total_cnt = 0, glitch_exp = 0;
  typedef struct {logic rise; int cyc;} ev_t;
  ev_t sb[$];
  ev_t mon_e;

  flick_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flick_raw(flick_raw),
    .flick_out(flick_out), .flick_rise(flick_rise), .flick_fall(flick_fall)
`ifdef FLICK_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (flick_rise === 1'b1 || flick_fall === 1'b1) begin
      total_cnt++;
      if (flick_rise === 1'b1 && flick_fall === 1'b1)
        $display("FAIL strobe_both rise=%b fall=%b required only one high", flick_rise, flick_fall);
      else if (sb.size() == 0)
        $display("FAIL unexpected_strobe rise=%b fall=%b edge=%0d required no strobe", flick_rise, flick_fall, cyc);
      else begin
        mon_e = sb.pop_front();
        if (mon_e.rise !== flick_rise || mon_e.cyc !== cyc)
          $display("FAIL strobe_timing rise=%b edge=%0d required rise=%b edge=%0d", flick_rise, cyc, mon_e.rise, mon_e.cyc);
        else pass_cnt++;
      end
    end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flick_raw = 1'b1;
    glitch_exp = 0;
    step(3);
    total_cnt++;
    if (flick_out !== 1'b0) $display("FAIL reset_out got=%b required=0", flick_out); else pass_cnt++;
    total_cnt++;
    if (flick_rise !== 1'b0) $display("FAIL reset_rise got=%b required=0", flick_rise); else pass_cnt++;
    total_cnt++;
    if (flick_fall !== 1'b0) $display("FAIL reset_fall got=%b required=0", flick_fall); else pass_cnt++;
`ifdef FLICK_GLITCH_CNT_EN
    total_cnt++;
    if (glitch_cnt !== 8'd0) $display("FAIL reset_glitch got=%0d required=0", glitch_cnt); else pass_cnt++;
`endif
    reset = 1'b1;
    sb.push_back('{1'b1, cyc + 1 + D + 1});
    wait_sb(20);
    total_cnt++;
    if (sb.size() != 0) begin
      $display("FAIL release_rise_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end else pass_cnt++;
    total_cnt++;
    if (flick_out !== 1'b1) $display("FAIL release_out got=%b required=1", flick_out); else pass_cnt++;
    step(1);
    total_cnt++;
    if (flick_rise !== 1'b0) $display("FAIL release_rise_width got=%b required=0", flick_rise); else pass_cnt++;
  endtask

  task automatic test_press_release();
    flick_raw = 1'b0;
    sb.push_back('{1'b0, cyc + 1 + D + 1});
    wait_sb(20);
    total_cnt++;
    if (sb.size() != 0 || flick_out !== 1'b0) begin
      $display("FAIL release_fall pending=%0d out=%b required pending=0 out=0", sb.size(), flick_out);
      sb.delete();
    end else pass_cnt++;
    step(3);
    flick_raw = 1'b1;
    sb.push_back('{1'b1, cyc + 1 + D + 1});
    step(10);
    total_cnt++;
    if (sb.size() != 0 || flick_out !== 1'b1) begin
      $display("FAIL press_rise pending=%0d out=%b required pending=0 out=1", sb.size(), flick_out);
      sb.delete();
    end else pass_cnt++;
    flick_raw = 1'b0;
    sb.push_back('{1'b0, cyc + 1 + D + 1});
    wait_sb(20);
    total_cnt++;
    if (sb.size() != 0 || flick_out !== 1'b0) begin
      $display("FAIL press_fall pending=%0d out=%b required pending=0 out=0", sb.size(), flick_out);
      sb.delete();
    end else pass_cnt++;
    step(3);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 4; i++) begin
      flick_raw = (i % 2 == 0);
      step(1);
    end
    flick_raw = 1'b1;
    glitch_exp += 2;
    sb.push_back('{1'b1, cyc + 1 + D + 1});
    wait_sb(20);
    total_cnt++;
    if (sb.size() != 0 || flick_out !== 1'b1) begin
      $display("FAIL bounce_rise pending=%0d out=%b required pending=0 out=1", sb.size(), flick_out);
      sb.delete();
    end else pass_cnt++;
`ifdef FLICK_GLITCH_CNT_EN
    total_cnt++;
    if (glitch_cnt !== 8'(glitch_exp)) $display("FAIL bounce_glitch got=%0d required=%0d", glitch_cnt, glitch_exp); else pass_cnt++;
`endif
    flick_raw = 1'b0;
    sb.push_back('{1'b0, cyc + 1 + D + 1});
    wait_sb(20);
    total_cnt++;
    if (sb.size() != 0 || flick_out !== 1'b0) begin
      $display("FAIL bounce_fall pending=%0d out=%b required pending=0 out=0", sb.size(), flick_out);
      sb.delete();
    end else pass_cnt++;
    step(3);
  endtask

  task automatic test_glitch();
    flick_raw = 1'b1;
    step(3);
    flick_raw = 1'b0;
    glitch_exp += 1;
    step(10);
    total_cnt++;
    if (flick_out !== 1'b0) $display("FAIL glitch_out got=%b required=0", flick_out); else pass_cnt++;
`ifdef FLICK_GLITCH_CNT_EN
    total_cnt++;
    if (glitch_cnt !== 8'(glitch_exp)) $display("FAIL glitch_cnt got=%0d required=%0d", glitch_cnt, glitch_exp); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    flick_raw = 1'b1;
    step(4);
    reset = 1'b0;
    step(1);
    glitch_exp = 0;
    total_cnt++;
    if (flick_out !== 1'b0 || flick_rise !== 1'b0)
      $display("FAIL midreset out=%b rise=%b required out=0 rise=0", flick_out, flick_rise);
    else pass_cnt++;
`ifdef FLICK_GLITCH_CNT_EN
    total_cnt++;
    if (glitch_cnt !== 8'd0) $display("FAIL midreset_glitch got=%0d required=0", glitch_cnt); else pass_cnt++;
`endif
    step(1);
    reset = 1'b1;
    sb.push_back('{1'b1, cyc + 1 + D + 1});
    wait_sb(20);
    total_cnt++;
    if (sb.size() != 0 || flick_out !== 1'b1) begin
      $display("FAIL midreset_rise pending=%0d out=%b required pending=0 out=1", sb.size(), flick_out);
      sb.delete();
    end else pass_cnt++;
    flick_raw = 1'b0;
    sb.push_back('{1'b0, cyc + 1 + D + 1});
    wait_sb(20);
    total_cnt++;
    if (sb.size() != 0 || flick_out !== 1'b0) begin
      $display("FAIL midreset_fall pending=%0d out=%b required pending=0 out=0", sb.size(), flick_out);
      sb.delete();
    end else pass_cnt++;
    step(3);
  endtask

`ifdef FLICK_GLITCH_CNT_EN
  task automatic test_saturation();
    repeat (260) begin
      flick_raw = 1'b1;
      step(3);
      flick_raw = 1'b0;
      step(4);
      glitch_exp = (glitch_exp < 255) ? glitch_exp + 1 : 255;
    end
    total_cnt++;
    if (glitch_cnt !== 8'(glitch_exp)) $display("FAIL sat_glitch got=%0d required=%0d", glitch_cnt, glitch_exp); else pass_cnt++;
    total_cnt++;
    if (flick_out !== 1'b0) $display("FAIL sat_out got=%b required=0", flick_out); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_glitch();
    test_reset_mid();
`ifdef FLICK_GLITCH_CNT_EN
    test_saturation();
`endif
    step(5);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1);
  end
endmodule
